rr_resp_route_bridge: RTL and testbench

Response-side companion to the bridge's round-robin request arbitration. Records, in grant order, the index of each master whose request the slave port accepts. Routes each in-order slave response (r_valid/r_rdata/r_opc) back to the originating master. Throttles the slave-side request when its ID FIFO cannot accept another outstanding transaction.

---
 rtl/rr_resp_route_bridge_pkg.sv | 14 +
 rtl/rr_resp_route_bridge_id_fifo.sv | 66 ++++++
 rtl/rr_resp_route_bridge.sv | 72 +++++++
 tb/tb_rr_resp_route_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rr_resp_route_bridge_pkg.sv
// Shared bridge definitions: default sizing, master-index type and response bundle.
package rr_resp_route_bridge_pkg;
    localparam int RR_N_MASTER_DEF   = 4;
    localparam int RR_ID_WIDTH_DEF   = $clog2(RR_N_MASTER_DEF);
    localparam int RR_DEPTH_DEF      = 4;
    localparam int RR_DATA_WIDTH_DEF = 32;

    typedef logic [RR_ID_WIDTH_DEF-1:0] master_id_t;

    typedef struct packed {
        logic [RR_DATA_WIDTH_DEF-1:0] rdata;
        logic                         opc;
    } resp_t;
endpackage

// File: rtl/rr_resp_route_bridge_id_fifo.sv
// In-order FIFO of granted master indices; any DEPTH >= 1, pointers wrap at DEPTH-1.
module rr_resp_id_fifo
    import rr_resp_route_bridge_pkg::*;
#(
    parameter int W     = RR_ID_WIDTH_DEF,
    parameter int DEPTH = RR_DEPTH_DEF,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     data_i,
    input  logic             pop_i,
    output logic [W-1:0]     data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push)
            wptr_d = (wptr_q == PTR_W'(DEPTH-1)) ? '0 : wptr_q + 1'b1;
        if (do_pop)
            rptr_d = (rptr_q == PTR_W'(DEPTH-1)) ? '0 : rptr_q + 1'b1;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/rr_resp_route_bridge.sv
// Tracks granted master indices in order and routes in-order slave responses back to them.
module rr_resp_route_bridge
    import rr_resp_route_bridge_pkg::*;
#(
    parameter int N_MASTER   = RR_N_MASTER_DEF,
    parameter int ID_WIDTH   = $clog2(N_MASTER),
    parameter int DEPTH      = RR_DEPTH_DEF,
    parameter int DATA_WIDTH = RR_DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ID_WIDTH-1:0]            req_master_id_i,
    input  logic                           data_req_i,
    output logic                           data_req_o,
    input  logic                           data_gnt_i,
    output logic                           data_gnt_o,
    input  logic                           data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
    input  logic                           data_r_opc_i,
    output logic [N_MASTER-1:0]            data_r_valid_o,
    output logic [N_MASTER*DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [N_MASTER-1:0]            data_r_opc_o,
    output logic [CNT_WIDTH-1:0]           outstanding_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           unexpected_rsp_o
);
    logic [ID_WIDTH-1:0] head;
    logic                push, pop;
    logic                unexp_q, unexp_d;

    // Throttle only on full: a same-cycle pop does not reopen the request path.
    assign data_req_o = data_req_i & ~full_o;
    assign data_gnt_o = data_gnt_i & data_req_o;
    assign push       = data_req_o & data_gnt_i;
    assign pop        = data_r_valid_i & ~empty_o;

    rr_resp_id_fifo #(
        .W     (ID_WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_WIDTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (req_master_id_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full_o),
        .empty_o (empty_o),
        .count_o (outstanding_o)
    );

    // Out-of-range head indices match no bit, so their responses vanish.
    always_comb begin
        data_r_valid_o = '0;
        for (int i = 0; i < N_MASTER; i++)
            data_r_valid_o[i] = pop & (head == ID_WIDTH'(i));
    end

    assign data_r_rdata_o = {N_MASTER{data_r_rdata_i}};
    assign data_r_opc_o   = {N_MASTER{data_r_opc_i}};

    assign unexp_d          = unexp_q | (data_r_valid_i & empty_o);
    assign unexpected_rsp_o = unexp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) unexp_q <= 1'b0;
        else        unexp_q <= unexp_d;
    end
endmodule

// File: tb/tb_rr_resp_route_bridge.sv
// Directed table-driven bench for rr_resp_route_bridge plus sticky-error and reset sequences.
module tb_rr_resp_route_bridge;
    localparam int NM = 4;
    localparam int IW = 2;
    localparam int DP = 4;
    localparam int DW = 32;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [IW-1:0]     req_master_id_i;
    logic              data_req_i, data_gnt_i;
    logic              data_req_o, data_gnt_o;
    logic              data_r_valid_i;
    logic [DW-1:0]     data_r_rdata_i;
    logic              data_r_opc_i;
    logic [NM-1:0]     data_r_valid_o;
    logic [NM*DW-1:0]  data_r_rdata_o;
    logic [NM-1:0]     data_r_opc_o;
    logic [CW-1:0]     outstanding_o;
    logic              full_o, empty_o, unexpected_rsp_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_resp_route_bridge #(.N_MASTER(NM), .DEPTH(DP), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_master_id_i  (req_master_id_i),
        .data_req_i       (data_req_i),
        .data_req_o       (data_req_o),
        .data_gnt_i       (data_gnt_i),
        .data_gnt_o       (data_gnt_o),
        .data_r_valid_i   (data_r_valid_i),
        .data_r_rdata_i   (data_r_rdata_i),
        .data_r_opc_i     (data_r_opc_i),
        .data_r_valid_o   (data_r_valid_o),
        .data_r_rdata_o   (data_r_rdata_o),
        .data_r_opc_o     (data_r_opc_o),
        .outstanding_o    (outstanding_o),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .unexpected_rsp_o (unexpected_rsp_o)
    );

    typedef struct {
        logic          req;
        logic [IW-1:0] id;
        logic          gnt;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          opc;
        logic          e_req;
        logic          e_gnt;
        logic [NM-1:0] e_v;
        logic [CW-1:0] e_cnt;
        logic          e_full;
        logic          e_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected values in each row describe the cycle before the rising edge.
    function automatic vec_t mk(input logic req, input logic [IW-1:0] id, input logic gnt,
                                input logic rv, input logic [DW-1:0] rdata, input logic opc,
                                input logic e_req, input logic e_gnt, input logic [NM-1:0] e_v,
                                input logic [CW-1:0] e_cnt, input logic e_full, input logic e_empty);
        vec_t v;
        v.req = req; v.id = id; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.opc = opc;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_v = e_v; v.e_cnt = e_cnt;
        v.e_full = e_full; v.e_empty = e_empty;
        return v;
    endfunction

    task automatic drive(input logic req, input logic [IW-1:0] id, input logic gnt,
                         input logic rv, input logic [DW-1:0] rdata, input logic opc);
        data_req_i = req; req_master_id_i = id; data_gnt_i = gnt;
        data_r_valid_i = rv; data_r_rdata_i = rdata; data_r_opc_i = opc;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        //          req id gnt rv rdata         opc  ereq egnt ev       cnt full empty
        // single read of master 2
        vecs.push_back(mk(1, 2, 1, 0, 32'h0,        0, 1, 1, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 4'b0100, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 0, 0, 1));
        // back-to-back grants 0,1,3,2
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 1, 1, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 1, 1, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(1, 3, 1, 0, 32'h0,        0, 1, 1, 4'b0000, 2, 0, 0));
        vecs.push_back(mk(1, 2, 1, 0, 32'h0,        0, 1, 1, 4'b0000, 3, 0, 0));
        // full: request blocked even though a response pops this cycle
        vecs.push_back(mk(1, 1, 1, 1, 32'h000000A1, 1, 0, 0, 4'b0001, 4, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 1, 1, 4'b0000, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h000000A2, 0, 0, 0, 4'b0010, 4, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h000000A3, 1, 0, 0, 4'b1000, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h000000A4, 0, 0, 0, 4'b0100, 2, 0, 0));
        // refill to 2, then six simultaneous push/pop cycles crossing the wrap
        vecs.push_back(mk(1, 3, 1, 0, 32'h0,        0, 1, 1, 4'b0000, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 32'h11111111, 0, 1, 1, 4'b0010, 2, 0, 0));
        vecs.push_back(mk(1, 2, 1, 1, 32'h22222222, 1, 1, 1, 4'b1000, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h33333333, 0, 1, 1, 4'b0001, 2, 0, 0));
        vecs.push_back(mk(1, 3, 1, 1, 32'h44444444, 1, 1, 1, 4'b0100, 2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 32'h55555555, 0, 1, 1, 4'b0010, 2, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 32'h66666666, 1, 1, 1, 4'b1000, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h77777777, 0, 0, 0, 4'b0001, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h88888888, 1, 0, 0, 4'b0010, 1, 0, 0));
        // request without grant, grant without request: no push
        vecs.push_back(mk(1, 3, 0, 0, 32'h0,        0, 1, 0, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 3, 1, 0, 32'h0,        0, 0, 0, 4'b0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 0, 0, 1));

        repeat (2) @(negedge clk);
        chk("reset_cnt", outstanding_o, 0);
        chk("reset_empty", empty_o, 1);
        chk("reset_full", full_o, 0);
        chk("reset_unexp", unexpected_rsp_o, 0);
        chk("reset_valid", data_r_valid_o, 0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].req, vecs[k].id, vecs[k].gnt, vecs[k].rv, vecs[k].rdata, vecs[k].opc);
            #1;
            chk($sformatf("v%0d_req_o", k), data_req_o, vecs[k].e_req);
            chk($sformatf("v%0d_gnt_o", k), data_gnt_o, vecs[k].e_gnt);
            chk($sformatf("v%0d_valid", k), data_r_valid_o, vecs[k].e_v);
            chk($sformatf("v%0d_cnt", k), outstanding_o, vecs[k].e_cnt);
            chk($sformatf("v%0d_full", k), full_o, vecs[k].e_full);
            chk($sformatf("v%0d_empty", k), empty_o, vecs[k].e_empty);
            chk($sformatf("v%0d_unexp", k), unexpected_rsp_o, 0);
            if (vecs[k].rv) begin
                for (int m = 0; m < NM; m++) begin
                    chk($sformatf("v%0d_rdata%0d", k, m), data_r_rdata_o[m*DW +: DW], vecs[k].rdata);
                    chk($sformatf("v%0d_opc%0d", k, m), data_r_opc_o[m], vecs[k].opc);
                end
            end
            @(negedge clk);
        end

        // response while empty: dropped, sticky flag holds
        drive(0, 0, 0, 1, 32'hBAD0BAD0, 1);
        #1;
        chk("unexp_valid", data_r_valid_o, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("unexp_hold%0d", c), unexpected_rsp_o, 1);
            chk($sformatf("unexp_cnt%0d", c), outstanding_o, 0);
            @(negedge clk);
        end

        // three outstanding, then asynchronous reset mid-cycle
        for (int c = 0; c < 3; c++) begin
            drive(1, IW'(c), 1, 0, 0, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("pre_rst_cnt", outstanding_o, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", outstanding_o, 0);
        chk("async_rst_empty", empty_o, 1);
        chk("async_rst_unexp", unexpected_rsp_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 32'hCAFEF00D, 0);
        #1;
        chk("post_rst_valid", data_r_valid_o, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_unexp", unexpected_rsp_o, 1);
        chk("post_rst_cnt", outstanding_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
